// File: rtl/key_edge_detect.sv
// Key front-end: synchronises a raw key pin and reports debounced edges as one-cycle pulses.
// Latency: pin change sampled at edge k gives a pulse registered at edge k+2 (when idle).
// No backpressure; start-up blanking and a post-edge lockout defer, never drop, level changes.
module key_edge_detect #(
  parameter logic [19:0] STARTUP_CYCLES = 20'd5_000,
  parameter logic [19:0] LOCK_CYCLES    = 20'd500_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic Pin_In,
  output logic H2L_Sig,
  output logic L2H_Sig,
  output logic Key_Level,
  output logic Busy
);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_LOCK    = 2'd2
  } state_t;

  // Terminal counts; the counter starts at 0 on each state entry.
  localparam logic [19:0] STARTUP_LAST = STARTUP_CYCLES - 20'd1;
  localparam logic [19:0] LOCK_LAST    = LOCK_CYCLES - 20'd1;

  logic        s1;
  logic        s2;
  state_t      state;
  logic [19:0] cnt;

  // Two-flop synchroniser; resets to the idle (released) pin level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= Pin_In;
      s2 <= s1;
    end
  end

  // Control FSM with registered pulse, level and busy outputs.
  // Busy is loaded with (next state != IDLE) so it rises with the pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_STARTUP;
      cnt       <= 20'd0;
      H2L_Sig   <= 1'b0;
      L2H_Sig   <= 1'b0;
      Key_Level <= 1'b1;
      Busy      <= 1'b1;
    end else begin
      H2L_Sig <= 1'b0;
      L2H_Sig <= 1'b0;
      case (state)
        ST_STARTUP: begin
          if (cnt == STARTUP_LAST) begin
            // Adopt the settled pin level silently: power-up is not an edge.
            Key_Level <= s2;
            state     <= ST_IDLE;
            cnt       <= 20'd0;
            Busy      <= 1'b0;
          end else begin
            cnt  <= cnt + 20'd1;
            Busy <= 1'b1;
          end
        end
        ST_IDLE: begin
          cnt <= 20'd0;
          if (s2 != Key_Level) begin
            // Any mismatch here, including one that arose during lockout, is reported now.
            Key_Level <= s2;
            H2L_Sig   <= ~s2;
            L2H_Sig   <= s2;
            state     <= ST_LOCK;
            Busy      <= 1'b1;
          end else begin
            Busy <= 1'b0;
          end
        end
        ST_LOCK: begin
          // Pin is ignored while locked; bounce is absorbed here.
          if (cnt == LOCK_LAST) begin
            state <= ST_IDLE;
            cnt   <= 20'd0;
            Busy  <= 1'b0;
          end else begin
            cnt  <= cnt + 20'd1;
            Busy <= 1'b1;
          end
        end
        default: begin
          state <= ST_STARTUP;
          cnt   <= 20'd0;
          Busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_edge_detect.sv
// Directed bench for key_edge_detect with STARTUP_CYCLES=8, LOCK_CYCLES=16.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Pulse activity is tallied by a monitor and compared against hand-derived counts.
module tb_key_edge_detect;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Pin_In = 1'b1;
  logic H2L_Sig;
  logic L2H_Sig;
  logic Key_Level;
  logic Busy;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor tallies (written only by the monitor).
  int cyc = 0;
  int h2l_cnt = 0;
  int l2h_cnt = 0;
  int h2l_cyc = 0;
  int l2h_cyc = 0;
  int overlap_cnt = 0;
  int double_cnt = 0;
  logic prev_pulse = 1'b0;

  int h2l_base;
  int l2h_base;

  key_edge_detect #(
    .STARTUP_CYCLES(20'd8),
    .LOCK_CYCLES   (20'd16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Pin_In   (Pin_In),
    .H2L_Sig  (H2L_Sig),
    .L2H_Sig  (L2H_Sig),
    .Key_Level(Key_Level),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Count pulses and flag simultaneous or stretched pulses.
  always @(negedge CLK) begin
    if (H2L_Sig === 1'b1) begin
      h2l_cnt <= h2l_cnt + 1;
      h2l_cyc <= cyc;
    end
    if (L2H_Sig === 1'b1) begin
      l2h_cnt <= l2h_cnt + 1;
      l2h_cyc <= cyc;
    end
    if (H2L_Sig === 1'b1 && L2H_Sig === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if (prev_pulse && (H2L_Sig === 1'b1 || L2H_Sig === 1'b1)) double_cnt <= double_cnt + 1;
    prev_pulse <= (H2L_Sig === 1'b1) || (L2H_Sig === 1'b1);
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    // ---- 1: reset with pin held low ----
    RST = 1'b1;
    Pin_In = 1'b0;
    cycles(2);
    chk_bit("rst_h2l", H2L_Sig, 1'b0);
    chk_bit("rst_l2h", L2H_Sig, 1'b0);
    chk_bit("rst_level", Key_Level, 1'b1);
    chk_bit("rst_busy", Busy, 1'b1);
    RST = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycles(1);
      chk_bit("t1_busy_startup", Busy, 1'b1);
    end
    cycles(1);
    chk_bit("t1_busy_fall", Busy, 1'b0);
    chk_bit("t1_level_low", Key_Level, 1'b0);
    cycles(5);
    chk_int("t1_no_h2l", h2l_cnt, 0);
    chk_int("t1_no_l2h", l2h_cnt, 0);

    // Release so the next test starts from a high level.
    Pin_In = 1'b1;
    cycles(30);
    chk_int("rel_l2h", l2h_cnt, 1);
    chk_bit("rel_level", Key_Level, 1'b1);

    // ---- 2: clean press ----
    h2l_base = h2l_cnt;
    l2h_base = l2h_cnt;
    Pin_In = 1'b0;                    // sampled at edge k
    cycles(2);                        // after k+1
    chk_bit("t2_no_early_pulse", H2L_Sig, 1'b0);
    cycles(1);                        // after k+2
    chk_bit("t2_h2l", H2L_Sig, 1'b1);
    chk_bit("t2_level", Key_Level, 1'b0);
    chk_bit("t2_busy_rise", Busy, 1'b1);
    cycles(1);                        // after k+3
    chk_bit("t2_h2l_one_cycle", H2L_Sig, 1'b0);
    for (int i = 4; i <= 17; i++) begin
      cycles(1);
      chk_bit("t2_busy_lock", Busy, 1'b1);
    end
    cycles(1);                        // after k+18
    chk_bit("t2_busy_fall", Busy, 1'b0);
    chk_int("t2_h2l_count", h2l_cnt - h2l_base, 1);
    chk_int("t2_l2h_count", l2h_cnt - l2h_base, 0);

    // ---- 3: bounce settling low ----
    Pin_In = 1'b1;
    cycles(30);
    h2l_base = h2l_cnt;
    l2h_base = l2h_cnt;
    for (int i = 0; i < 12; i++) begin
      Pin_In = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      cycles(1);
    end
    Pin_In = 1'b0;
    cycles(30);
    chk_int("t3_h2l_count", h2l_cnt - h2l_base, 1);
    chk_int("t3_l2h_count", l2h_cnt - l2h_base, 0);
    chk_bit("t3_level", Key_Level, 1'b0);

    // ---- 4: release during lockout ----
    Pin_In = 1'b1;
    cycles(30);
    h2l_base = h2l_cnt;
    l2h_base = l2h_cnt;
    Pin_In = 1'b0;                    // sampled at edge k
    cycles(3);                        // after k+2
    chk_bit("t4_h2l", H2L_Sig, 1'b1);
    cycles(2);                        // after k+4
    Pin_In = 1'b1;                    // sampled at edge k+5
    cycles(13);                       // after k+17
    chk_bit("t4_busy_end_lock", Busy, 1'b1);
    cycles(1);                        // after k+18
    chk_bit("t4_busy_gap", Busy, 1'b0);
    chk_bit("t4_no_early_l2h", L2H_Sig, 1'b0);
    cycles(1);                        // after k+19
    chk_bit("t4_l2h", L2H_Sig, 1'b1);
    chk_bit("t4_busy_relock", Busy, 1'b1);
    chk_bit("t4_level", Key_Level, 1'b1);
    cycles(20);
    chk_int("t4_spacing", l2h_cyc - h2l_cyc, 17);
    chk_int("t4_h2l_count", h2l_cnt - h2l_base, 1);
    chk_int("t4_l2h_count", l2h_cnt - l2h_base, 1);
    chk_bit("t4_final_level", Key_Level, 1'b1);

    // ---- 5: reset mid-lockout ----
    h2l_base = h2l_cnt;
    l2h_base = l2h_cnt;
    Pin_In = 1'b0;                    // sampled at edge k, pulse at k+2
    cycles(8);                        // after k+7, lock count 5
    chk_bit("t5_locked", Busy, 1'b1);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    chk_bit("t5_busy", Busy, 1'b1);
    chk_bit("t5_level", Key_Level, 1'b1);
    chk_bit("t5_no_h2l", H2L_Sig, 1'b0);
    chk_bit("t5_no_l2h", L2H_Sig, 1'b0);
    cycles(7);
    chk_bit("t5_busy_startup", Busy, 1'b1);
    cycles(1);
    chk_bit("t5_busy_fall", Busy, 1'b0);
    chk_bit("t5_level_low", Key_Level, 1'b0);
    cycles(5);
    chk_int("t5_h2l_count", h2l_cnt - h2l_base, 1);
    chk_int("t5_l2h_count", l2h_cnt - l2h_base, 0);

    // ---- 6: glitch during start-up ----
    Pin_In = 1'b1;
    RST = 1'b1;
    cycles(2);
    h2l_base = h2l_cnt;
    l2h_base = l2h_cnt;
    RST = 1'b0;
    cycles(1);                        // after e1
    Pin_In = 1'b0;                    // low for edges e2..e4
    cycles(3);
    Pin_In = 1'b1;
    cycles(3);                        // after e7
    chk_bit("t6_busy_startup", Busy, 1'b1);
    cycles(1);                        // after e8
    chk_bit("t6_busy_fall", Busy, 1'b0);
    chk_bit("t6_level", Key_Level, 1'b1);
    cycles(20);
    chk_int("t6_h2l_count", h2l_cnt - h2l_base, 0);
    chk_int("t6_l2h_count", l2h_cnt - l2h_base, 0);

    // ---- global pulse-shape properties ----
    chk_int("pulse_overlap", overlap_cnt, 0);
    chk_int("pulse_stretch", double_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
